snes_pad_shifter: RTL and testbench

Console-facing serial output stage for TAS playback. It sits between the frame buffer and the SNES controller port pins, consuming the console's latch and clock pulses (12 µs latch every ~16.67 ms, then 16 × 12 µs-period clock pulses idling high). On each latch it pops one 16-bit button frame from an internal FIFO and serialises it onto the data line. Upstream logic fills the FIFO through a valid/ready handshake.

---
 rtl/snes_pad_shifter.sv | 126 ++++++++++++
 tb/tb_snes_pad_shifter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/snes_pad_shifter.sv
// SNES controller-port serialiser: synchronises the console latch/clock pins,
// pops one button frame per latch from a small FIFO and shifts it out active-low.
module snes_pad_shifter #(
  parameter int FIFO_DEPTH = 4,
  parameter int BITS       = 16
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          snes_lat,
  input  logic                          snes_clk,
  input  logic [BITS-1:0]               frame_data,
  input  logic                          frame_valid,
  output logic                          frame_ready,
  output logic                          snes_dat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   latch_count,
  output logic                          underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int IW = $clog2(BITS) + 1;

  typedef enum logic [1:0] {IDLE, LATCHED, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        lat_sync_q, lat_sync_d;
  logic [2:0]        clk_sync_q, clk_sync_d;
  logic [BITS-1:0]   shift_q, shift_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              uf_q, uf_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [BITS-1:0]   mem_q [FIFO_DEPTH];

  logic lat_rise, lat_fall, clk_rise, push, pop;

  // Bits [1:0] are the synchroniser, bit 2 holds the previous synchronised level.
  assign lat_rise = lat_sync_q[1] & ~lat_sync_q[2];
  assign lat_fall = ~lat_sync_q[1] & lat_sync_q[2];
  assign clk_rise = clk_sync_q[1] & ~clk_sync_q[2];

  assign frame_ready = (level_q < LW'(FIFO_DEPTH));
  assign push        = frame_valid && frame_ready;
  assign pop         = lat_rise && (level_q != '0);

  always_comb begin
    lat_sync_d = {lat_sync_q[1:0], snes_lat};
    clk_sync_d = {clk_sync_q[1:0], snes_clk};
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    uf_d       = 1'b0;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);

    if (lat_rise) begin
      // A new latch always wins, even mid-shift; an empty FIFO shifts all zeros.
      shift_d = pop ? mem_q[rd_ptr_q] : '0;
      uf_d    = ~pop;
      cnt_d   = cnt_q + 16'd1;
      idx_d   = '0;
      state_d = LATCHED;
    end else begin
      case (state_q)
        LATCHED: if (lat_fall) state_d = SHIFT;
        SHIFT: begin
          if (clk_rise) begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q << 1;
            if (idx_d == IW'(BITS)) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      LATCHED, SHIFT: snes_dat = ~shift_q[BITS-1];
      DONE:           snes_dat = 1'b0;
      default:        snes_dat = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_sync_q <= '0;
      clk_sync_q <= '1;
      shift_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      uf_q       <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      lat_sync_q <= lat_sync_d;
      clk_sync_q <= clk_sync_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      uf_q       <= uf_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= frame_data;
  end

  assign fifo_level  = level_q;
  assign latch_count = cnt_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_snes_pad_shifter.sv
// Directed bench for snes_pad_shifter: latch/clock pin sequences against
// hand-derived data-pin, FIFO level, latch count and underflow values.
module tb_snes_pad_shifter;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        snes_lat;
  logic        snes_clk;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        snes_dat;
  logic [2:0]  fifo_level;
  logic [15:0] latch_count;
  logic        underflow;

  int n_cmp = 0;
  int n_err = 0;

  snes_pad_shifter #(.FIFO_DEPTH(4), .BITS(16)) dut (
    .sys_clk(sys_clk), .reset(reset), .snes_lat(snes_lat), .snes_clk(snes_clk),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .snes_dat(snes_dat), .fifo_level(fifo_level), .latch_count(latch_count),
    .underflow(underflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Drive a pin level, then wait the three edges it takes to reach the outputs.
  task automatic pin_lat(input logic v);
    @(negedge sys_clk);
    snes_lat = v;
    tick(3);
  endtask

  task automatic pin_clk(input logic v);
    @(negedge sys_clk);
    snes_clk = v;
    tick(3);
  endtask

  task automatic clk_pulse();
    pin_clk(1'b0);
    pin_clk(1'b1);
  endtask

  task automatic push(input logic [15:0] d);
    @(negedge sys_clk);
    frame_data  = d;
    frame_valid = 1'b1;
    tick(1);
    frame_valid = 1'b0;
  endtask

  // After clock k the pin carries ~word[15-k]; after the 16th it reads DONE (0).
  task automatic shift_check(input string tag, input logic [15:0] word, input int n);
    logic exp;
    for (int k = 1; k <= n; k++) begin
      clk_pulse();
      exp = (k < 16) ? ~word[15-k] : 1'b0;
      chk($sformatf("%s_clk%0d", tag, k), 32'(snes_dat), 32'(exp));
    end
  endtask

  initial begin
    reset = 1'b1; snes_lat = 1'b0; snes_clk = 1'b1;
    frame_data = '0; frame_valid = 1'b0;
    tick(3);
    chk("rst_dat", 32'(snes_dat), 1);
    chk("rst_ready", 32'(frame_ready), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_count", 32'(latch_count), 0);
    chk("rst_uf", 32'(underflow), 0);
    @(negedge sys_clk); reset = 1'b0;
    tick(2);

    // Empty latch: exact 3-edge latency, one underflow pulse, all-ones pin.
    @(negedge sys_clk); snes_lat = 1'b1;
    tick(2);
    chk("lat1_early_count", 32'(latch_count), 0);
    chk("lat1_early_uf", 32'(underflow), 0);
    tick(1);
    chk("lat1_uf", 32'(underflow), 1);
    chk("lat1_count", 32'(latch_count), 1);
    chk("lat1_dat", 32'(snes_dat), 1);
    tick(1);
    chk("lat1_uf_pulse", 32'(underflow), 0);
    pin_lat(1'b0);
    shift_check("empty", 16'h0000, 16);
    chk("empty_uf_after", 32'(underflow), 0);

    // Single frame 0x8001, then extra clocks in DONE.
    push(16'h8001);
    chk("p1_level", 32'(fifo_level), 1);
    @(negedge sys_clk); snes_lat = 1'b1;
    tick(2);
    chk("p1_level_pre", 32'(fifo_level), 1);
    tick(1);
    chk("p1_level_pop", 32'(fifo_level), 0);
    chk("p1_dat", 32'(snes_dat), 0);
    chk("p1_count", 32'(latch_count), 2);
    chk("p1_uf", 32'(underflow), 0);
    pin_lat(1'b0);
    shift_check("f8001", 16'h8001, 16);
    clk_pulse();
    chk("done_clk17", 32'(snes_dat), 0);
    clk_pulse();
    chk("done_clk18", 32'(snes_dat), 0);

    // Fill the FIFO; a held fifth word must wait.
    push(16'hA5C3); push(16'h0F0F); push(16'hFFFF); push(16'h1234);
    chk("full_level", 32'(fifo_level), 4);
    chk("full_ready", 32'(frame_ready), 0);
    @(negedge sys_clk); frame_data = 16'h5555; frame_valid = 1'b1;
    tick(5);
    chk("held_level", 32'(fifo_level), 4);
    chk("held_ready", 32'(frame_ready), 0);
    pin_lat(1'b1);
    chk("fullpop_level", 32'(fifo_level), 3);
    chk("fullpop_ready", 32'(frame_ready), 1);
    chk("fullpop_count", 32'(latch_count), 3);
    chk("fullpop_dat", 32'(snes_dat), 0);
    tick(1);
    chk("refill_level", 32'(fifo_level), 4);
    chk("refill_ready", 32'(frame_ready), 0);
    @(negedge sys_clk); frame_valid = 1'b0;

    // Clock pulses while latched are ignored.
    clk_pulse(); clk_pulse();
    chk("latched_dat", 32'(snes_dat), 0);
    pin_lat(1'b0);
    shift_check("fA5C3", 16'hA5C3, 8);

    // Re-latch mid-shift restarts on the next frame.
    pin_lat(1'b1);
    chk("relat_count", 32'(latch_count), 4);
    chk("relat_level", 32'(fifo_level), 3);
    chk("relat_dat", 32'(snes_dat), 1);
    chk("relat_uf", 32'(underflow), 0);
    pin_lat(1'b0);
    shift_check("f0F0F", 16'h0F0F, 4);

    // Push and pop landing on the same edge leave the level unchanged.
    @(negedge sys_clk); snes_lat = 1'b1;
    @(posedge sys_clk); @(posedge sys_clk);
    @(negedge sys_clk); frame_data = 16'h7E81; frame_valid = 1'b1;
    tick(1);
    chk("pushpop_level", 32'(fifo_level), 3);
    chk("pushpop_count", 32'(latch_count), 5);
    chk("pushpop_dat", 32'(snes_dat), 0);
    @(negedge sys_clk); frame_valid = 1'b0;
    pin_lat(1'b0);
    shift_check("fFFFF", 16'hFFFF, 5);

    // Reset mid-frame with three frames queued.
    @(negedge sys_clk); reset = 1'b1;
    tick(1);
    chk("mid_rst_dat", 32'(snes_dat), 1);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_count", 32'(latch_count), 0);
    chk("mid_rst_ready", 32'(frame_ready), 1);
    chk("mid_rst_uf", 32'(underflow), 0);
    @(negedge sys_clk); reset = 1'b0;
    clk_pulse(); clk_pulse();
    chk("idle_dat", 32'(snes_dat), 1);
    push(16'h4000);
    pin_lat(1'b1);
    chk("post_rst_count", 32'(latch_count), 1);
    chk("post_rst_level", 32'(fifo_level), 0);
    chk("post_rst_uf", 32'(underflow), 0);
    chk("post_rst_dat", 32'(snes_dat), 1);
    pin_lat(1'b0);
    shift_check("f4000", 16'h4000, 1);

    // Push into an empty FIFO on the latch edge: underflow, word kept.
    @(negedge sys_clk); snes_lat = 1'b1;
    @(posedge sys_clk); @(posedge sys_clk);
    @(negedge sys_clk); frame_data = 16'h0001; frame_valid = 1'b1;
    tick(1);
    chk("emptypush_uf", 32'(underflow), 1);
    chk("emptypush_level", 32'(fifo_level), 1);
    chk("emptypush_count", 32'(latch_count), 2);
    chk("emptypush_dat", 32'(snes_dat), 1);
    @(negedge sys_clk); frame_valid = 1'b0;
    tick(1);
    chk("emptypush_uf_pulse", 32'(underflow), 0);
    pin_lat(1'b0);
    pin_lat(1'b1);
    chk("kept_count", 32'(latch_count), 3);
    chk("kept_level", 32'(fifo_level), 0);
    chk("kept_uf", 32'(underflow), 0);
    chk("kept_dat", 32'(snes_dat), 1);
    pin_lat(1'b0);
    shift_check("f0001", 16'h0001, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
